// File: rtl/hdmi_tx_pkg.sv
// Shared HDMI TX definitions: video period encoding and CTL patterns used by
// the timing generator and the per-channel encoder mux.
package hdmi_tx_pkg;

    typedef enum logic [1:0] {
        PeriodCtrl     = 2'b00,
        PeriodPreamble = 2'b01,
        PeriodGuard    = 2'b10,
        PeriodVideo    = 2'b11
    } period_t;

    localparam logic [3:0] CTL_VIDEO_PREAMBLE = 4'b0001;
    localparam logic [3:0] CTL_IDLE           = 4'b0000;

endpackage

// File: rtl/wrap_counter.sv
// Modulo counter with synchronous load; count_next exposes the value the
// counter takes at the next edge so callers can register decoded outputs.
module wrap_counter #(
    parameter int unsigned Width    = 12,
    parameter int unsigned Modulus  = 800,
    parameter int unsigned ResetVal = 0
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             inc,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    output logic [Width-1:0] count,
    output logic [Width-1:0] count_next,
    output logic             wrap
);

    localparam logic [Width-1:0] Last = Width'(Modulus - 1);
    localparam logic [Width-1:0] Rst  = Width'(ResetVal);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        wrap = inc && (count_q == Last);
        if (load) begin
            count_d = load_val;
        end else if (wrap) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + Width'(1);
        end else begin
            count_d = count_q;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= Rst;
        end else begin
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/video_timing_generator.sv
// Raster timing for the HDMI TX path: h/v counters, DE, syncs and the HDMI
// video period sequence. All outputs are registered decodes of the next (h, v).
module video_timing_generator
    import hdmi_tx_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned H_FP         = 16,
    parameter int unsigned H_SYNC       = 96,
    parameter int unsigned H_BP         = 48,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned V_FP         = 10,
    parameter int unsigned V_SYNC       = 2,
    parameter int unsigned V_BP         = 33,
    parameter logic        HSYNC_POL    = 1'b0,
    parameter logic        VSYNC_POL    = 1'b0,
    parameter int unsigned PREAMBLE_LEN = 8,
    parameter int unsigned GUARD_LEN    = 2,
    parameter int unsigned CW           = 12
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          enable,
    output logic          de,
    output logic          hsync,
    output logic          vsync,
    output logic [1:0]    period,
    output logic [3:0]    ctl,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] HActive    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] HSyncStart = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HSyncEnd   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] PreStart   = CW'(H_TOTAL - PREAMBLE_LEN - GUARD_LEN);
    localparam logic [CW-1:0] GuardStart = CW'(H_TOTAL - GUARD_LEN);
    localparam logic [CW-1:0] VActive    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] VSyncStart = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VSyncEnd   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] VLast      = CW'(V_TOTAL - 1);

    if (H_BP < PREAMBLE_LEN + GUARD_LEN) begin : g_err_bp
        $error("H_BP too short for preamble plus guard band");
    end
    if (CW < 32 && ((64'd1 << CW) <= 64'(H_TOTAL - 1) || (64'd1 << CW) <= 64'(V_TOTAL - 1)))
    begin : g_err_cw
        $error("CW too narrow for H_TOTAL/V_TOTAL");
    end

    logic [CW-1:0] h_cnt, h_nxt, v_cnt, v_nxt, nv;
    logic          h_wrap, v_wrap, nv_active;

    wrap_counter #(
        .Width    (CW),
        .Modulus  (H_TOTAL),
        .ResetVal (0)
    ) u_h_cnt (
        .clk        (clk),
        .n_rst      (n_rst),
        .inc        (enable),
        .load       (!enable),
        .load_val   ('0),
        .count      (h_cnt),
        .count_next (h_nxt),
        .wrap       (h_wrap)
    );

    // Disabled raster parks on the first front-porch line.
    wrap_counter #(
        .Width    (CW),
        .Modulus  (V_TOTAL),
        .ResetVal (V_ACTIVE)
    ) u_v_cnt (
        .clk        (clk),
        .n_rst      (n_rst),
        .inc        (h_wrap),
        .load       (!enable),
        .load_val   (VActive),
        .count      (v_cnt),
        .count_next (v_nxt),
        .wrap       (v_wrap)
    );

    logic       de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d, fs_q, fs_d;
    period_t    period_q, period_d;
    logic [3:0] ctl_q, ctl_d;

    always_comb begin
        nv        = (v_nxt == VLast) ? '0 : v_nxt + CW'(1);
        nv_active = nv < VActive;
        de_d      = (h_nxt < HActive) && (v_nxt < VActive);
        hsync_d   = ((h_nxt >= HSyncStart) && (h_nxt < HSyncEnd)) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d   = ((v_nxt >= VSyncStart) && (v_nxt < VSyncEnd)) ? VSYNC_POL : ~VSYNC_POL;
        period_d  = PeriodCtrl;
        if (de_d) begin
            period_d = PeriodVideo;
        end else if (nv_active && (h_nxt >= PreStart) && (h_nxt < GuardStart)) begin
            period_d = PeriodPreamble;
        end else if (nv_active && (h_nxt >= GuardStart)) begin
            period_d = PeriodGuard;
        end
        ctl_d = (period_d == PeriodPreamble) ? CTL_VIDEO_PREAMBLE : CTL_IDLE;
        // v only wraps on an h wrap, so this marks the edge into (0, 0).
        fs_d  = v_wrap;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            de_q     <= 1'b0;
            hsync_q  <= ~HSYNC_POL;
            vsync_q  <= ~VSYNC_POL;
            period_q <= PeriodCtrl;
            ctl_q    <= CTL_IDLE;
            fs_q     <= 1'b0;
        end else begin
            de_q     <= de_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            period_q <= period_d;
            ctl_q    <= ctl_d;
            fs_q     <= fs_d;
        end
    end

    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign period      = period_q;
    assign ctl         = ctl_q;
    assign pixel_x     = h_cnt;
    assign pixel_y     = v_cnt;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_video_timing_generator.sv
// Scoreboard bench for video_timing_generator on a shrunken raster (66 x 21)
// so several whole frames fit in a short run.
module tb_video_timing_generator;

    localparam int HA = 40, HF = 6, HS = 8, HB = 12;
    localparam int VA = 12, VF = 3, VS = 2, VB = 4;
    localparam int PL = 8, GL = 2, CW = 12;
    localparam int HT = HA + HF + HS + HB;  // 66
    localparam int VT = VA + VF + VS + VB;  // 21

    logic          clk = 1'b0, n_rst = 1'b0, enable = 1'b0;
    logic          de, hsync, vsync, frame_start;
    logic [1:0]    period;
    logic [3:0]    ctl;
    logic [CW-1:0] pixel_x, pixel_y;

    video_timing_generator #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .HSYNC_POL (1'b0), .VSYNC_POL (1'b0),
        .PREAMBLE_LEN (PL), .GUARD_LEN (GL), .CW (CW)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .enable      (enable),
        .de          (de),
        .hsync       (hsync),
        .vsync       (vsync),
        .period      (period),
        .ctl         (ctl),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          de, hs, vs;
        logic [1:0]    per;
        logic [3:0]    ctl;
        logic [CW-1:0] x, y;
        logic          fs;
    } obs_t;

    obs_t exp_q[$];
    int   tests = 0, fails = 0;
    int   hm = 0, vm = VA;
    int   cyc = 0, fs_cnt = 0, fs_last = 0, fs_intv = 0, mark = 0;
    int   de_c[VT], hs_c[VT], vs_c[VT], pre_c[VT], grd_c[VT];
    int   de_a[VT], hs_a[VT], vs_a[VT], pre_a[VT], grd_a[VT];

    function automatic obs_t model(input int h, input int v);
        obs_t o;
        int   nv;
        nv    = (v + 1) % VT;
        o.de  = (h < HA) && (v < VA);
        o.hs  = (h >= HA + HF && h < HA + HF + HS) ? 1'b0 : 1'b1;
        o.vs  = (v >= VA + VF && v < VA + VF + VS) ? 1'b0 : 1'b1;
        if (o.de) o.per = 2'b11;
        else if (nv < VA && h >= HT - PL - GL && h < HT - GL) o.per = 2'b01;
        else if (nv < VA && h >= HT - GL) o.per = 2'b10;
        else o.per = 2'b00;
        o.ctl = (o.per == 2'b01) ? 4'b0001 : 4'b0000;
        o.x   = CW'(h);
        o.y   = CW'(v);
        o.fs  = (h == 0) && (v == 0);
        return o;
    endfunction

    // Called at a falling edge: drives enable and queues the state expected after the next rise.
    task automatic step(input logic en);
        enable = en;
        if (!n_rst || !en) begin
            hm = 0;
            vm = VA;
        end else begin
            hm++;
            if (hm == HT) begin
                hm = 0;
                vm++;
                if (vm == VT) vm = 0;
            end
        end
        exp_q.push_back(model(hm, vm));
        @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic run_until_fs(input int target);
        for (int i = 0; i < 3000 && fs_cnt < target; i++) step(1'b1);
        check("frame_start_reached", fs_cnt, target);
    endtask

    initial begin : monitor
        obs_t act, req;
        int   y;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            act = {de, hsync, vsync, period, ctl, pixel_x, pixel_y, frame_start};
            if (exp_q.size() != 0) begin
                req = exp_q.pop_front();
                tests++;
                if (act !== req) begin
                    fails++;
                    $display("FAIL scoreboard cyc=%0d actual=%h required=%h", cyc, act, req);
                end
            end
            if (n_rst) begin
                y = int'(pixel_y);
                if (y < VT) begin
                    if (de) de_c[y]++;
                    if (!hsync) hs_c[y]++;
                    if (!vsync) vs_c[y]++;
                    if (period == 2'b01) pre_c[y]++;
                    if (period == 2'b10) grd_c[y]++;
                end
                if (frame_start) begin
                    fs_cnt++;
                    fs_intv = cyc - fs_last;
                    fs_last = cyc;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        obs_t act;
        @(negedge clk);
        repeat (3) step(1'b1);
        n_rst = 1'b1;
        mark  = cyc;
        run_until_fs(1);
        check("first_fs_latency", fs_last - mark, 594);
        de_a = de_c; hs_a = hs_c; vs_a = vs_c; pre_a = pre_c; grd_a = grd_c;

        run_until_fs(2);
        check("frame_interval", fs_intv, HT * VT);
        check("de_line3", de_c[3] - de_a[3], 40);
        check("de_line11", de_c[11] - de_a[11], 40);
        check("de_line12", de_c[12] - de_a[12], 0);
        check("hsync_line3", hs_c[3] - hs_a[3], 8);
        check("hsync_blank14", hs_c[14] - hs_a[14], 8);
        check("vsync_line14", vs_c[14] - vs_a[14], 0);
        check("vsync_line15", vs_c[15] - vs_a[15], 66);
        check("vsync_line16", vs_c[16] - vs_a[16], 66);
        check("vsync_line17", vs_c[17] - vs_a[17], 0);
        check("preamble_line20", pre_c[20] - pre_a[20], 8);
        check("guard_line20", grd_c[20] - grd_a[20], 2);
        check("preamble_line5", pre_c[5] - pre_a[5], 8);
        check("preamble_line11", pre_c[11] - pre_a[11], 0);
        check("guard_line11", grd_c[11] - grd_a[11], 0);

        for (int i = 0; i < 3000 && !(hm == 20 && vm == 3); i++) step(1'b1);
        repeat (4) step(1'b0);
        check("park_y", int'(pixel_y), VA);
        mark = cyc;
        run_until_fs(3);
        check("reenable_fs_latency", fs_last - mark, 594);

        for (int i = 0; i < 3000 && !(hm == 20 && vm == 5); i++) step(1'b1);
        check("pre_reset_de", int'(de), 1);
        #2;
        n_rst = 1'b0;
        #1;
        act = {de, hsync, vsync, period, ctl, pixel_x, pixel_y, frame_start};
        tests++;
        if (act !== model(0, VA)) begin
            fails++;
            $display("FAIL async_reset actual=%h required=%h", act, model(0, VA));
        end
        repeat (3) step(1'b1);
        n_rst = 1'b1;
        mark  = cyc;
        repeat (HT) step(1'b1);
        check("line_after_release_x", int'(pixel_x), 0);
        check("line_after_release_y", int'(pixel_y), VA + 1);
        run_until_fs(4);
        check("post_reset_fs_latency", fs_last - mark, 594);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/video_timing_generator.md
Name: video_timing_generator

Overview:
- Generates raster timing for the HDMI TX path: horizontal/vertical counters, DE, HSYNC/VSYNC, and the HDMI video period sequence (control, preamble, guard band, active video).
- Sits directly upstream of the per-channel TMDS video data encoders.
- Its period/ctl outputs select, per cycle, what each channel carries: encoded pixel, control symbol, or guard band.
- pixel_x/pixel_y drive the pixel source.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (cycles)
H_SYNC, 96, hsync width (cycles)
H_BP, 48, horizontal back porch (cycles); must be >= PREAMBLE_LEN+GUARD_LEN
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, asserted level of hsync
VSYNC_POL, 0, asserted level of vsync
PREAMBLE_LEN, 8, video preamble length (cycles)
GUARD_LEN, 2, video guard band length (cycles)
CW, 12, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  input  1  pixel clock
n_rst  input  1  reset, asynchronous, active-low
enable  input  1  run raster; low parks counters
de  output  1  data enable, high during active video
hsync  output  1  horizontal sync, polarity HSYNC_POL
vsync  output  1  vertical sync, polarity VSYNC_POL
period  output  2  00 CTRL, 01 PREAMBLE, 10 GUARD, 11 VIDEO
ctl  output  4  CTL3..CTL0; 4'b0001 during PREAMBLE, else 0
pixel_x  output  CW  current h count
pixel_y  output  CW  current v count
frame_start  output  1  one-cycle pulse at h=0, v=0

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800. V_TOTAL = 525 at defaults.
- Counters h, v: h increments every enabled cycle and wraps H_TOTAL-1 -> 0. v increments on each h wrap and wraps V_TOTAL-1 -> 0. Both counters wrap in the same cycle at (H_TOTAL-1, V_TOTAL-1).
- Park state: (h=0, v=V_ACTIVE), i.e. the first front-porch line. The first frame therefore begins after a full vertical blank, with correct preamble/guard.
- Reset: async to the park state.
  - Reset values: de=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, period=CTRL, ctl=0, frame_start=0, pixel_x=0, pixel_y=V_ACTIVE.
- enable low: the next edge loads the park state; counters hold there while low. Outputs decode the park state. Counting resumes on the first edge with enable high.
- Output alignment: every output is registered and is a pure function of the (h, v) currently held. Implement by decoding next-state values into output registers; zero skew between pixel_x/pixel_y and the other outputs.
- de = (h < H_ACTIVE) && (v < V_ACTIVE).
- hsync asserted iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, on every line including blank lines.
- vsync asserted iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for whole lines (transitions at h=0).
- Period decode (priority order):
  - VIDEO when de.
  - PREAMBLE when next line nv=(v+1) mod V_TOTAL < V_ACTIVE and H_TOTAL-PREAMBLE_LEN-GUARD_LEN <= h < H_TOTAL-GUARD_LEN.
  - GUARD when the same nv condition holds and h >= H_TOTAL-GUARD_LEN.
  - else CTRL.
- No preamble/guard before blank lines. Preamble and guard are always contiguous and immediately precede VIDEO.
- ctl = 4'b0001 only while period==PREAMBLE.
- frame_start: high exactly in the cycle (h, v) = (0, 0).
- Elaboration checks: error if H_BP < PREAMBLE_LEN+GUARD_LEN, or if 2**CW <= H_TOTAL-1 or 2**CW <= V_TOTAL-1.

Decomposition:
- Package hdmi_tx_pkg: period_t enum (CTRL, PREAMBLE, GUARD, VIDEO), CTL_VIDEO_PREAMBLE = 4'b0001, CTL_IDLE = 4'b0000. Shared with the encoder/channel mux.
- One sub-module: wrap_counter, parameterised width and modulus, with inputs inc and load_val/load, output wrap. Instantiated twice: h, and v with inc = h wrap.

Test Plan:
1. Reset release, enable=1 -> first cycle pixel_x=0, pixel_y=480, de=0, hsync=1, vsync=1, period=CTRL; pixel_y=481 after 800 cycles.
2. Active line v=10 -> de=1 for exactly h=0..639 (640 cycles); hsync=0 for h=656..751 (96 cycles); period=VIDEO iff de.
3. Line v=524 -> PREAMBLE with ctl=0001 at h=790..797, GUARD at h=798..799, then VIDEO at h=0, v=0. Line v=479 -> period=CTRL at h=790..799 (no preamble).
4. Frame wrap -> h=799, v=524 goes to h=0, v=0 with frame_start=1 for one cycle; consecutive frame_start pulses exactly 420000 cycles apart; vsync=0 on lines 490..491 only.
5. enable dropped at h=100, v=10 -> next cycle h=0, v=480, de=0, syncs inactive, period=CTRL, held while low. Re-enable -> first frame_start after exactly 36000 cycles.
6. Async reset asserted mid-VIDEO (h=300, v=200) -> outputs take reset values immediately without a clock edge; behaviour identical to scenario 1 after release.
